dpd_lut_gain: RTL and testbench

Downstream consumer of the complex-magnitude stage in the DPD datapath. Uses the 20-bit magnitude to index a complex-gain LUT, multiplies the time-aligned I/Q sample by that gain, and emits the predistorted 20-bit I/Q stream. The LUT is double-banked so host updates never disturb the live stream. Contents are initialised to unity gain by an internal FSM after reset.

---
 rtl/dpd_pkg.sv | 16 +
 rtl/dpd_cmult_sat.sv | 69 ++++++
 rtl/dpd_lut_gain.sv | 144 ++++++++++++++
 tb/tb_dpd_lut_gain.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_pkg.sv
// Shared constants for the DPD datapath: widths, Q1.14 gain format and LUT FSM state codes.
package dpd_pkg;

  localparam int DPD_DW      = 20;
  localparam int DPD_COEF_W  = 16;
  localparam int DPD_ADDR_W  = 8;
  localparam int DPD_Q_SHIFT = 14;
  localparam int DPD_UNITY   = 16384;
  localparam int DPD_MAG_LAT = 14;

  typedef logic [0:0] lut_state_t;

  localparam lut_state_t ST_INIT = 1'b0;
  localparam lut_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/dpd_cmult_sat.sv
// Two-stage complex multiply x*g with a Q-format round-half-up and saturation back to DW bits.
module dpd_cmult_sat
  import dpd_pkg::*;
#(
  parameter int DW    = DPD_DW,
  parameter int CW    = DPD_COEF_W,
  parameter int SHIFT = DPD_Q_SHIFT
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] x_q,
  input  logic signed [CW-1:0] g_i,
  input  logic signed [CW-1:0] g_q,
  output logic signed [DW-1:0] y_i,
  output logic signed [DW-1:0] y_q
);

  localparam int PW = DW + CW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND   = SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [DW-1:0] round_sat(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] sh;
    sh = (acc + RND) >>> SHIFT;
    if (sh > MAX_V)      return MAX_V[DW-1:0];
    else if (sh < MIN_V) return MIN_V[DW-1:0];
    else                 return sh[DW-1:0];
  endfunction

  logic signed [PW-1:0] xi_w, xq_w, gi_w, gq_w;
  logic signed [PW-1:0] p_ii_q, p_qq_q, p_iq_q, p_qi_q;
  logic signed [SW-1:0] re_acc, im_acc;
  logic signed [DW-1:0] y_i_d, y_q_d, y_i_q, y_q_q;

  assign xi_w = PW'(x_i);
  assign xq_w = PW'(x_q);
  assign gi_w = PW'(g_i);
  assign gq_w = PW'(g_q);

  assign re_acc = SW'(p_ii_q) - SW'(p_qq_q);
  assign im_acc = SW'(p_iq_q) + SW'(p_qi_q);
  assign y_i_d  = round_sat(re_acc);
  assign y_q_d  = round_sat(im_acc);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      p_ii_q <= '0;
      p_qq_q <= '0;
      p_iq_q <= '0;
      p_qi_q <= '0;
      y_i_q  <= '0;
      y_q_q  <= '0;
    end else begin
      p_ii_q <= xi_w * gi_w;
      p_qq_q <= xq_w * gq_w;
      p_iq_q <= xi_w * gq_w;
      p_qi_q <= xq_w * gi_w;
      y_i_q  <= y_i_d;
      y_q_q  <= y_q_d;
    end
  end

  assign y_i = y_i_q;
  assign y_q = y_q_q;

endmodule

// File: rtl/dpd_lut_gain.sv
// Magnitude-indexed complex-gain LUT applied to the time-aligned I/Q stream.
// Two banks: one is read by the datapath, the other takes host writes until swapped in.
module dpd_lut_gain
  import dpd_pkg::*;
#(
  parameter int DW      = DPD_DW,
  parameter int ADDR_W  = DPD_ADDR_W,
  parameter int COEF_W  = DPD_COEF_W,
  parameter int MAG_LAT = DPD_MAG_LAT
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic signed [DW-1:0]     sig_in_i,
  input  logic signed [DW-1:0]     sig_in_q,
  input  logic        [DW-1:0]     magn,
  input  logic                     bypass,
  input  logic                     cfg_we,
  input  logic        [ADDR_W-1:0] cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_coef_i,
  input  logic signed [COEF_W-1:0] cfg_coef_q,
  input  logic                     cfg_swap,
  output logic                     init_done,
  output logic                     active_bank,
  output logic signed [DW-1:0]     sig_out_i,
  output logic signed [DW-1:0]     sig_out_q,
  output logic                     out_valid
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MW     = 2 * COEF_W;
  localparam int FILL   = MAG_LAT + 3;
  localparam int FILL_W = $clog2(FILL + 1);
  localparam logic [FILL_W-1:0] FILL_END = FILL_W'(FILL);
  localparam logic [COEF_W-1:0] UNITY_C  = COEF_W'(DPD_UNITY);

  lut_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              active_bank_q;
  logic [FILL_W-1:0] fill_q;
  logic              in_init;

  assign in_init = (state_q == ST_INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_init) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      active_bank_q <= 1'b0;
      fill_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!in_init && cfg_swap) active_bank_q <= ~active_bank_q;
      if (fill_q != FILL_END) fill_q <= fill_q + 1'b1;
    end
  end

  assign init_done   = (state_q == ST_RUN);
  assign out_valid   = (fill_q == FILL_END);
  assign active_bank = active_bank_q;

  // INIT sweeps unity into both banks at once; afterwards only the shadow bank is writable.
  logic [ADDR_W-1:0] wr_addr, lut_addr;
  logic [MW-1:0]     wr_data;
  logic              unused_magn;

  assign wr_addr     = in_init ? cnt_q : cfg_addr;
  assign wr_data     = in_init ? {UNITY_C, {COEF_W{1'b0}}} : {cfg_coef_i, cfg_coef_q};
  assign lut_addr    = magn[DW-1 -: ADDR_W];
  assign unused_magn = ^magn[DW-ADDR_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [MW-1:0] mem [DEPTH];
      logic [MW-1:0] rd_q;
      logic          we;

      assign we = in_init || (cfg_we && (active_bank_q != 1'(gi)));

      always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_q <= mem[lut_addr];
      end
    end
  endgenerate

  // Bank select and unity override are captured with the read so the mux sees a consistent S1 view.
  logic              sel_q, force_q;
  logic signed [DW-1:0] dly_i_q [MAG_LAT+1];
  logic signed [DW-1:0] dly_q_q [MAG_LAT+1];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sel_q   <= 1'b0;
      force_q <= 1'b1;
      for (int i = 0; i <= MAG_LAT; i++) begin
        dly_i_q[i] <= '0;
        dly_q_q[i] <= '0;
      end
    end else begin
      sel_q      <= active_bank_q;
      force_q    <= bypass || in_init;
      dly_i_q[0] <= sig_in_i;
      dly_q_q[0] <= sig_in_q;
      for (int i = 1; i <= MAG_LAT; i++) begin
        dly_i_q[i] <= dly_i_q[i-1];
        dly_q_q[i] <= dly_q_q[i-1];
      end
    end
  end

  logic [MW-1:0]            rd_sel;
  logic signed [COEF_W-1:0] gain_i, gain_q;

  assign rd_sel = sel_q ? g_bank[1].rd_q : g_bank[0].rd_q;
  assign gain_i = force_q ? UNITY_C : rd_sel[MW-1:COEF_W];
  assign gain_q = force_q ? '0 : rd_sel[COEF_W-1:0];

  dpd_cmult_sat #(
    .DW   (DW),
    .CW   (COEF_W),
    .SHIFT(DPD_Q_SHIFT)
  ) u_cmult (
    .clk    (clk),
    .reset_b(reset_b),
    .x_i    (dly_i_q[MAG_LAT]),
    .x_q    (dly_q_q[MAG_LAT]),
    .g_i    (gain_i),
    .g_q    (gain_q),
    .y_i    (sig_out_i),
    .y_q    (sig_out_q)
  );

endmodule

// File: tb/tb_dpd_lut_gain.sv
// Randomized and directed bench for dpd_lut_gain against a cycle-indexed behavioural model.
module tb_dpd_lut_gain;

  localparam int UNITY = 16384;
  localparam int MLAT  = 14;

  logic               clk = 1'b0;
  logic               reset_b = 1'b0;
  logic signed [19:0] sig_in_i = '0, sig_in_q = '0;
  logic        [19:0] magn = '0;
  logic               bypass = 1'b0, cfg_we = 1'b0, cfg_swap = 1'b0;
  logic        [7:0]  cfg_addr = '0;
  logic signed [15:0] cfg_coef_i = '0, cfg_coef_q = '0;
  logic               init_done, active_bank, out_valid;
  logic signed [19:0] sig_out_i, sig_out_q;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dpd_lut_gain dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .sig_in_i   (sig_in_i),
    .sig_in_q   (sig_in_q),
    .magn       (magn),
    .bypass     (bypass),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_coef_i (cfg_coef_i),
    .cfg_coef_q (cfg_coef_q),
    .cfg_swap   (cfg_swap),
    .init_done  (init_done),
    .active_bank(active_bank),
    .sig_out_i  (sig_out_i),
    .sig_out_q  (sig_out_q),
    .out_valid  (out_valid)
  );

  // ---------------- behavioural model ----------------
  int k;
  int act;
  int lut_i [2][256];
  int lut_q [2][256];
  int sh_i [32], sh_q [32];
  int y_i [32], y_q [32];
  int exp_i, exp_q, exp_valid, exp_done, exp_bank;

  function automatic int rnd_sat(input longint p);
    longint r;
    r = (p + 64'sd8192) >>> 14;
    if (r > 524287)  r = 524287;
    if (r < -524288) r = -524288;
    return int'(r);
  endfunction

  task automatic model_reset();
    k = 0;
    act = 0;
    exp_i = 0; exp_q = 0; exp_valid = 0; exp_done = 0; exp_bank = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        lut_i[b][a] = UNITY;
        lut_q[b][a] = 0;
      end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_b);
      if (!reset_b) begin
        model_reset();
      end else begin
        int gi, gq, xi, xq;
        bit init;
        k++;
        init = (k <= 256);
        sh_i[k % 32] = sig_in_i;
        sh_q[k % 32] = sig_in_q;
        if (bypass || init) begin
          gi = UNITY; gq = 0;
        end else begin
          gi = lut_i[act][int'(magn[19:12])];
          gq = lut_q[act][int'(magn[19:12])];
        end
        xi = (k > MLAT) ? sh_i[(k - MLAT) % 32] : 0;
        xq = (k > MLAT) ? sh_q[(k - MLAT) % 32] : 0;
        y_i[k % 32] = rnd_sat(longint'(xi) * gi - longint'(xq) * gq);
        y_q[k % 32] = rnd_sat(longint'(xi) * gq + longint'(xq) * gi);
        if (!init) begin
          if (cfg_we) begin
            lut_i[1 - act][int'(cfg_addr)] = cfg_coef_i;
            lut_q[1 - act][int'(cfg_addr)] = cfg_coef_q;
          end
          if (cfg_swap) act = 1 - act;
        end
        exp_i     = (k >= 3) ? y_i[(k - 2) % 32] : 0;
        exp_q     = (k >= 3) ? y_q[(k - 2) % 32] : 0;
        exp_valid = (k >= MLAT + 3) ? 1 : 0;
        exp_done  = (k >= 256) ? 1 : 0;
        exp_bank  = act;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic chk(input string name, input int got, input int want);
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      chk("sig_out_i", int'(sig_out_i), exp_i);
      chk("sig_out_q", int'(sig_out_q), exp_q);
      chk("out_valid", int'(out_valid), exp_valid);
      chk("init_done", int'(init_done), exp_done);
      chk("active_bank", int'(active_bank), exp_bank);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic pin(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL pin %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("pin %s = %0d ok", name, got);
    end
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    cfg_we = 1'b0; cfg_swap = 1'b0; bypass = 1'b0;
    tick(3);
    reset_b = 1'b1;
    cyc = 0;
  endtask

  task automatic set_coef(input int addr, input int ci, input int cq);
    cfg_we = 1'b1; cfg_addr = 8'(addr); cfg_coef_i = 16'(ci); cfg_coef_q = 16'(cq);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic swap();
    cfg_swap = 1'b1;
    tick();
    cfg_swap = 1'b0;
  endtask

  task automatic drive(input int i, input int q, input int m, input int n = 20);
    sig_in_i = 20'(i); sig_in_q = 20'(q); magn = 20'(m);
    tick(n);
  endtask

  initial begin
    // Phase 1: reset, INIT timing, cfg ignored during INIT
    sig_in_i = 20'sd1000; sig_in_q = -20'sd500; magn = '0;
    tick(2);
    do_reset();
    pin("reset sig_out_i", int'(sig_out_i), 0);
    while (cyc < 270) begin
      cfg_we = (cyc >= 100 && cyc < 105);
      cfg_addr = '0; cfg_coef_i = '0; cfg_coef_q = '0;
      cfg_swap = (cyc == 102);
      tick();
      if (cyc == 16)  pin("out_valid@16", int'(out_valid), 0);
      if (cyc == 17)  pin("out_valid@17", int'(out_valid), 1);
      if (cyc == 30)  pin("unity I@30", int'(sig_out_i), 1000);
      if (cyc == 30)  pin("unity Q@30", int'(sig_out_q), -500);
      if (cyc == 255) pin("init_done@255", int'(init_done), 0);
      if (cyc == 256) pin("init_done@256", int'(init_done), 1);
    end
    cfg_we = 1'b0; cfg_swap = 1'b0;
    pin("bank after INIT", int'(active_bank), 0);
    pin("post-INIT I", int'(sig_out_i), 1000);

    // Phase 2: half gain, 3-cycle magn latency
    set_coef('h40, 8192, 0);
    swap();
    drive(2000, 400, 0);
    pin("bank1 addr0 unity I", int'(sig_out_i), 2000);
    magn = 20'h40000;
    tick(2);
    pin("magn+2 still old I", int'(sig_out_i), 2000);
    tick(1);
    pin("magn+3 half I", int'(sig_out_i), 1000);
    pin("magn+3 half Q", int'(sig_out_q), 200);

    // Phase 3: 90 degree rotation
    set_coef('h10, 0, 16384);
    swap();
    drive(300, 100, 'h10000);
    pin("rot I", int'(sig_out_i), -100);
    pin("rot Q", int'(sig_out_q), 300);

    // Phase 4: saturation and full-scale magnitude
    set_coef('h20, 32767, 0);
    set_coef('hFF, 8192, 0);
    swap();
    drive(524287, 0, 'h20000);
    pin("sat max I", int'(sig_out_i), 524287);
    drive(-524288, 0, 'h20000);
    pin("sat min I", int'(sig_out_i), -524288);
    drive(4000, 0, 'hFFFFF);
    pin("full-scale magn I", int'(sig_out_i), 2000);

    // Phase 5: shadow write without swap, then bypass
    set_coef('h20, 0, 0);
    drive(1000, 0, 'h20000);
    pin("shadow untouched I", int'(sig_out_i), 2000);
    bypass = 1'b1;
    drive(1000, -7, 'h20000);
    pin("bypass I", int'(sig_out_i), 1000);
    pin("bypass Q", int'(sig_out_q), -7);
    bypass = 1'b0;

    // Phase 6: randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int a;
      a = $urandom_range(0, 15);
      sig_in_i   = 20'($urandom);
      sig_in_q   = 20'($urandom);
      magn       = {8'(a * 16 + $urandom_range(0, 1)), 12'($urandom)};
      bypass     = ($urandom_range(0, 7) == 0);
      cfg_we     = $urandom_range(0, 1);
      cfg_addr   = 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 1));
      cfg_coef_i = 16'($urandom);
      cfg_coef_q = 16'($urandom);
      cfg_swap   = ($urandom_range(0, 31) == 0);
      tick();
    end
    cfg_we = 1'b0; cfg_swap = 1'b0; bypass = 1'b0;

    // Phase 7: known gain in both banks, then mid-stream reset restores unity
    set_coef('h20, 8192, 0);
    swap();
    set_coef('h20, 8192, 0);
    swap();
    if (act == 0) swap();
    drive(778, 0, 'h20000);
    pin("pre-reset half I", int'(sig_out_i), 389);
    pin("pre-reset bank", int'(active_bank), 1);
    do_reset();
    pin("in-reset sig_out_i", int'(sig_out_i), 0);
    pin("in-reset bank", int'(active_bank), 0);
    pin("in-reset out_valid", int'(out_valid), 0);
    while (cyc < 280) begin
      tick();
      if (cyc == 17)  pin("re-fill out_valid@17", int'(out_valid), 1);
      if (cyc == 256) pin("re-INIT init_done@256", int'(init_done), 1);
    end
    pin("post-reset unity I", int'(sig_out_i), 778);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
